// File: rtl/ntt_stage_sequencer_if.sv
// ntt_stage_sequencer_if
// Groups the control/status and memory-address signals of the NTT stage
// sequencer.
//   master : the controller side. It drives start/stall and observes everything else.
//   slave  : the sequencer itself.
// Signals:
//   start, stall            controller -> sequencer
//   busy, done, stage       status
//   rd_valid, rd_addr_*     butterfly read pair, tw_addr twiddle ROM address
//   wr_en, wr_addr_*        write-back pair, next_pair pulse to the reorder block
//   dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
interface ntt_stage_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [NUM_STAGES-1:0] stage;
  logic                  rd_valid;
  logic [NUM_STAGES-1:0] rd_addr_top;
  logic [NUM_STAGES-1:0] rd_addr_bot;
  logic [NUM_STAGES-2:0] tw_addr;
  logic                  wr_en;
  logic [NUM_STAGES-1:0] wr_addr_top;
  logic [NUM_STAGES-1:0] wr_addr_bot;
  logic                  next_pair;
  logic [1:0]            dbg_state;

  modport master (
    output start, stall,
    input  busy, done, stage, rd_valid, rd_addr_top, rd_addr_bot, tw_addr,
           wr_en, wr_addr_top, wr_addr_bot, next_pair, dbg_state
  );

  modport slave (
    input  start, stall,
    output busy, done, stage, rd_valid, rd_addr_top, rd_addr_bot, tw_addr,
           wr_en, wr_addr_top, wr_addr_bot, next_pair, dbg_state
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer
// Sequences an in-place radix-2 NTT of N = 2^NUM_STAGES points. For every
// butterfly of every stage, it issues the top/bottom read addresses and the
// twiddle address. The same addresses are delayed by BF_LATENCY cycles to form
// the write-back. Between stages the block idles for BF_LATENCY cycles so the
// pipeline can drain. On the final stage it emits next_pair with each write.
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    ntt_stage_sequencer_if.slave (start/stall in, all status and addresses out)
// Handshake: start is sampled only in IDLE. stall only blocks new issues,
// and only in ISSUE. rd_valid marks a read pair in the same cycle as its
// addresses. wr_en marks a write pair. All address outputs are 0 when
// their valid is low.
// The last write of a stage lands one cycle before the first read of the
// next stage. The data RAM must therefore be write-before-read or have a
// registered read.
module ntt_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int BF_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  ntt_stage_sequencer_if.slave  bus
);

  localparam int PW = NUM_STAGES - 1;
  localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(BF_LATENCY - 1);
  localparam logic [NUM_STAGES-1:0] LAST_STAGE = NUM_STAGES'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] HALF       = NUM_STAGES'(1) << (NUM_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_p;
  logic [NUM_STAGES-1:0] r_s;
  logic [DW-1:0]         r_drain;

  logic w_issue;
  logic w_last_pair;
  logic w_last_stage;
  logic w_drain_end;

  assign w_issue      = (r_state == S_ISSUE) && !bus.stall;
  assign w_last_pair  = &r_p;
  assign w_last_stage = (r_s == LAST_STAGE);
  assign w_drain_end  = (r_state == S_DRAIN) && (r_drain == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ISSUE;
      S_ISSUE: if (w_issue && w_last_pair) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_next = w_last_stage ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pair, stage and drain counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p     <= '0;
      r_s     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_p     <= '0;
            r_s     <= '0;
            r_drain <= '0;
          end
        end
        S_ISSUE: begin
          // p wraps back to 0 after the last pair of the stage.
          if (w_issue) r_p <= r_p + PW'(1);
          r_drain <= '0;
        end
        S_DRAIN: begin
          if (w_drain_end) begin
            r_drain <= '0;
            r_p     <= '0;
            if (!w_last_stage) r_s <= r_s + NUM_STAGES'(1);
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_DONE: begin
          // Leave the stage index at 0 while idle.
          r_p <= '0;
          r_s <= '0;
        end
        default: ;
      endcase
    end
  end

  // Address generation.
  // stride = 2^(NUM_STAGES-1-s), mask = stride-1.
  // The bits of p above the mask form the group g. Shifting them left by
  // one gives g*2*stride. The masked bits form j.
  // Bit log2(stride) of top is always 0, so OR-ing in stride gives top+stride.
  logic [NUM_STAGES-1:0] w_stride;
  logic [NUM_STAGES-1:0] w_mask;
  logic [NUM_STAGES-1:0] w_p_ext;
  logic [NUM_STAGES-1:0] w_top;
  logic [NUM_STAGES-1:0] w_bot;
  logic [PW-1:0]         w_j;
  logic [PW-1:0]         w_tw;

  always_comb begin
    w_stride = HALF >> r_s;
    w_mask   = w_stride - NUM_STAGES'(1);
    w_p_ext  = {1'b0, r_p};
    w_j      = r_p & w_mask[PW-1:0];
    w_top    = ((w_p_ext & ~w_mask) << 1) | (w_p_ext & w_mask);
    w_bot    = w_top | w_stride;
    w_tw     = w_j << r_s;
  end

  logic [NUM_STAGES-1:0] w_rd_top;
  logic [NUM_STAGES-1:0] w_rd_bot;
  logic [PW-1:0]         w_rd_tw;

  assign w_rd_top = w_issue ? w_top : '0;
  assign w_rd_bot = w_issue ? w_bot : '0;
  assign w_rd_tw  = w_issue ? w_tw  : '0;

  // Write-back pipeline: {valid, top, bot, last_stage}. A stall bubble
  // enters as valid=0 with zero addresses.
  logic                  r_pv [BF_LATENCY];
  logic                  r_pl [BF_LATENCY];
  logic [NUM_STAGES-1:0] r_pt [BF_LATENCY];
  logic [NUM_STAGES-1:0] r_pb [BF_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pl[i] <= 1'b0;
        r_pt[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue & w_last_stage;
      r_pt[0] <= w_rd_top;
      r_pb[0] <= w_rd_bot;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pt[i] <= r_pt[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.stage       = r_s;
  assign bus.rd_valid    = w_issue;
  assign bus.rd_addr_top = w_rd_top;
  assign bus.rd_addr_bot = w_rd_bot;
  assign bus.tw_addr     = w_rd_tw;
  assign bus.wr_en       = r_pv[BF_LATENCY-1];
  assign bus.wr_addr_top = r_pt[BF_LATENCY-1];
  assign bus.wr_addr_bot = r_pb[BF_LATENCY-1];
  assign bus.next_pair   = r_pv[BF_LATENCY-1] & r_pl[BF_LATENCY-1];
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
module tb_ntt_stage_sequencer;

  localparam int NS  = 4;
  localparam int LAT = 3;
  localparam int NP  = 8;
  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ntt_stage_sequencer_if #(.NUM_STAGES(NS)) bus ();

  ntt_stage_sequencer #(.NUM_STAGES(NS), .BF_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected per-cycle values of one run, cycle 0 = start sample cycle
  logic       e_rv [MAXC];
  logic [3:0] e_top[MAXC];
  logic [3:0] e_bot[MAXC];
  logic [2:0] e_tw [MAXC];
  logic [3:0] e_stg[MAXC];
  logic       e_we [MAXC];
  logic [3:0] e_wt [MAXC];
  logic [3:0] e_wb [MAXC];
  logic       e_np [MAXC];
  logic       e_dn [MAXC];
  logic       e_bsy[MAXC];

  // Observed values of the latest run
  logic       o_rv [MAXC];
  logic [3:0] o_top[MAXC];
  logic [3:0] o_bot[MAXC];
  logic [2:0] o_tw [MAXC];
  logic       o_we [MAXC];
  logic       o_np [MAXC];
  logic       o_dn [MAXC];

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Issue schedule with stall cycles lo..hi, using the plain div/mod address formulas.
  task automatic build(input int lo, input int hi);
    int c, stride, j, g, t;
    for (int i = 0; i < MAXC; i++) begin
      e_rv[i] = 0; e_top[i] = 0; e_bot[i] = 0; e_tw[i] = 0; e_stg[i] = 0;
      e_we[i] = 0; e_wt[i] = 0; e_wb[i] = 0; e_np[i] = 0; e_dn[i] = 0; e_bsy[i] = 0;
    end
    c = 1;
    for (int s = 0; s < NS; s++) begin
      stride = 1 << (NS - 1 - s);
      for (int p = 0; p < NP; p++) begin
        while (c >= lo && c <= hi) begin
          e_bsy[c] = 1; e_stg[c] = 4'(s); c++;
        end
        j = p % stride;
        g = p / stride;
        t = g * 2 * stride + j;
        e_rv[c] = 1; e_top[c] = 4'(t); e_bot[c] = 4'(t + stride);
        e_tw[c] = 3'((j * (1 << s)) % 8);
        e_bsy[c] = 1; e_stg[c] = 4'(s);
        e_we[c+LAT] = 1; e_wt[c+LAT] = 4'(t); e_wb[c+LAT] = 4'(t + stride);
        e_np[c+LAT] = (s == NS - 1);
        c++;
      end
      for (int d = 0; d < LAT; d++) begin
        e_bsy[c] = 1; e_stg[c] = 4'(s); c++;
      end
    end
    e_dn[c] = 1; e_bsy[c] = 1; e_stg[c] = 4'(NS - 1);
  endtask

  // Entered mid-cycle in IDLE. That cycle becomes cycle 0, with start raised for sampling.
  task automatic run(input int lo, input int hi, input int x1, input int x2, input int last);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    #1;
    chk("idle_busy", 0, 32'(bus.busy), 32'(0));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      bus.start = (c == x1) || (c == x2);
      bus.stall = (c >= lo) && (c <= hi);
      #1;
      o_rv[c] = bus.rd_valid; o_top[c] = bus.rd_addr_top; o_bot[c] = bus.rd_addr_bot;
      o_tw[c] = bus.tw_addr;  o_we[c] = bus.wr_en; o_np[c] = bus.next_pair; o_dn[c] = bus.done;
      chk("rd_valid",    c, 32'(bus.rd_valid),    32'(e_rv[c]));
      chk("rd_addr_top", c, 32'(bus.rd_addr_top), 32'(e_top[c]));
      chk("rd_addr_bot", c, 32'(bus.rd_addr_bot), 32'(e_bot[c]));
      chk("tw_addr",     c, 32'(bus.tw_addr),     32'(e_tw[c]));
      chk("stage",       c, 32'(bus.stage),       32'(e_stg[c]));
      chk("wr_en",       c, 32'(bus.wr_en),       32'(e_we[c]));
      chk("wr_addr_top", c, 32'(bus.wr_addr_top), 32'(e_wt[c]));
      chk("wr_addr_bot", c, 32'(bus.wr_addr_bot), 32'(e_wb[c]));
      chk("next_pair",   c, 32'(bus.next_pair),   32'(e_np[c]));
      chk("done",        c, 32'(bus.done),        32'(e_dn[c]));
      chk("busy",        c, 32'(bus.busy),        32'(e_bsy[c]));
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  initial begin
    int n_we, n_np, n_dn, first_np, last_np, dn_cyc;

    // Clock/reset
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      0, 32'(bus.busy),      32'(0));
    chk("rst_rd_valid",  0, 32'(bus.rd_valid),  32'(0));
    chk("rst_rd_bot",    0, 32'(bus.rd_addr_bot), 32'(0));
    chk("rst_wr_en",     0, 32'(bus.wr_en),     32'(0));
    chk("rst_dbg_state", 0, 32'(bus.dbg_state), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: full run with no stall
    build(-1, -1);
    run(-1, -1, -1, -1, 50);
    chk("s1_c1_top", 1, 32'(o_top[1]), 32'(0));
    chk("s1_c1_bot", 1, 32'(o_bot[1]), 32'(8));
    chk("s1_c8_top", 8, 32'(o_top[8]), 32'(7));
    chk("s1_c8_bot", 8, 32'(o_bot[8]), 32'(15));
    chk("s1_c8_tw",  8, 32'(o_tw[8]),  32'(7));
    for (int c = 9; c <= 11; c++) chk("s1_drain_rv", c, 32'(o_rv[c]), 32'(0));
    chk("s1_st1_p5_top", 17, 32'(o_top[17]), 32'(9));
    chk("s1_st1_p5_bot", 17, 32'(o_bot[17]), 32'(13));
    chk("s1_st1_p5_tw",  17, 32'(o_tw[17]),  32'(2));
    chk("s1_st3_last_top", 41, 32'(o_top[41]), 32'(14));
    chk("s1_st3_last_bot", 41, 32'(o_bot[41]), 32'(15));
    n_we = 0; n_np = 0; n_dn = 0; first_np = -1; last_np = -1; dn_cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      if (o_we[c]) n_we++;
      if (o_np[c]) begin n_np++; if (first_np < 0) first_np = c; last_np = c; end
      if (o_dn[c]) begin n_dn++; dn_cyc = c; end
    end
    chk("s1_wr_count",  0, 32'(n_we),     32'(32));
    chk("s1_np_count",  0, 32'(n_np),     32'(8));
    chk("s1_np_first",  0, 32'(first_np), 32'(37));
    chk("s1_np_last",   0, 32'(last_np),  32'(44));
    chk("s1_done_cnt",  0, 32'(n_dn),     32'(1));
    chk("s1_done_cyc",  0, 32'(dn_cyc),   32'(45));

    // Scenario 2: stall held over cycles 3-5 of stage 0
    @(posedge clk); #1;
    build(3, 5);
    run(3, 5, -1, -1, 52);
    for (int c = 3; c <= 5; c++) chk("s2_stall_rv", c, 32'(o_rv[c]), 32'(0));
    chk("s2_resume_top", 6, 32'(o_top[6]), 32'(2));
    chk("s2_resume_bot", 6, 32'(o_bot[6]), 32'(10));
    for (int c = 6; c <= 8; c++) chk("s2_wr_bubble", c, 32'(o_we[c]), 32'(0));
    dn_cyc = -1;
    for (int c = 1; c <= 52; c++) if (o_dn[c]) dn_cyc = c;
    chk("s2_done_cyc", 0, 32'(dn_cyc), 32'(48));

    // Scenario 3: reset at cycle 20, then a new start at cycle 25
    @(posedge clk); #1;
    build(-1, -1);
    run(-1, -1, -1, -1, 19);
    @(posedge clk); #1;
    chk("s3_pre_wr_en", 20, 32'(bus.wr_en), 32'(1));
    reset = 1'b1;
    #1;
    chk("s3_rst_busy",     20, 32'(bus.busy),        32'(0));
    chk("s3_rst_rd_valid", 20, 32'(bus.rd_valid),    32'(0));
    chk("s3_rst_stage",    20, 32'(bus.stage),       32'(0));
    chk("s3_rst_wr_en",    20, 32'(bus.wr_en),       32'(0));
    chk("s3_rst_wr_top",   20, 32'(bus.wr_addr_top), 32'(0));
    chk("s3_rst_wr_bot",   20, 32'(bus.wr_addr_bot), 32'(0));
    chk("s3_rst_np",       20, 32'(bus.next_pair),   32'(0));
    chk("s3_rst_done",     20, 32'(bus.done),        32'(0));
    for (int c = 21; c <= 24; c++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("s3_idle_wr_en", c, 32'(bus.wr_en),     32'(0));
      chk("s3_idle_np",    c, 32'(bus.next_pair), 32'(0));
      chk("s3_idle_busy",  c, 32'(bus.busy),      32'(0));
      chk("s3_idle_rv",    c, 32'(bus.rd_valid),  32'(0));
    end
    @(posedge clk); #1;
    run(-1, -1, -1, -1, 50);
    chk("s3_c1_bot", 1, 32'(o_bot[1]), 32'(8));
    dn_cyc = -1;
    for (int c = 1; c <= 50; c++) if (o_dn[c]) dn_cyc = c;
    chk("s3_done_cyc", 0, 32'(dn_cyc), 32'(45));

    // Scenario 4: start pulsed while busy (cycle 10) and in the DONE cycle (45)
    @(posedge clk); #1;
    build(-1, -1);
    run(-1, -1, 10, 45, 55);
    n_dn = 0; n_we = 0;
    for (int c = 1; c <= 55; c++) begin
      if (o_dn[c]) n_dn++;
      if (o_we[c]) n_we++;
    end
    chk("s4_done_cnt", 0, 32'(n_dn), 32'(1));
    chk("s4_wr_count", 0, 32'(n_we), 32'(32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
